// File: rtl/kmeans_sample_store.sv
// kmeans_sample_store: frame buffer feeding the k-means core and sink for its class labels.
// A valid/ready stream fills SAMPS x DIMS channels; the core reads samples by address
// with no latency, gets a start pulse once the frame is complete, then writes labels back.
module kmeans_sample_store #(
  parameter int unsigned W     = 16,
  parameter int unsigned DIMS  = 6,
  parameter int unsigned SAMPS = 128,
  parameter int unsigned K     = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              in_valid_i,
  input  logic [W-1:0]                      in_data_i,
  output logic                              in_ready_o,
  output logic                              start_o,
  output logic                              full_o,
  input  logic [$clog2(SAMPS)-1:0]          addr_i,
  output logic [DIMS-1:0][W-1:0]            membus_o,
  input  logic                              label_valid_i,
  input  logic [$clog2(K)-1:0]              label_i,
  input  logic [$clog2(SAMPS)-1:0]          label_raddr_i,
  output logic [$clog2(K)-1:0]              label_o,
  output logic                              labels_done_o,
  output logic                              label_err_o
);

  localparam int unsigned AW = $clog2(SAMPS);
  localparam int unsigned DW = $clog2(DIMS);
  localparam int unsigned LW = $clog2(K);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [AW-1:0]    s;
  logic [DW-1:0]    d;
  logic [SAMPS-1:0] lv;
  logic             accept;
  logic             label_bad;
  logic             label_wr;

  logic [W-1:0]     mem [SAMPS][DIMS];
  logic [LW-1:0]    lab [SAMPS];

  // Ready is withheld combinationally during a reset cycle so no beat is taken while resetting
  assign in_ready_o    = (state == LOAD) && !rst_i;
  assign full_o        = (state == FULL);
  assign labels_done_o = &lv;
  assign accept        = in_valid_i && in_ready_o && !clear_i;
  assign label_bad     = 32'(label_i) >= K;
  assign label_wr      = (state == FULL) && label_valid_i && !clear_i && !rst_i;

  // Control FSM: load counters, frame completion, label-valid bits and error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= LOAD;
      s           <= '0;
      d           <= '0;
      lv          <= '0;
      label_err_o <= 1'b0;
      start_o     <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (clear_i) begin
        state       <= LOAD;
        s           <= '0;
        d           <= '0;
        lv          <= '0;
        label_err_o <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              if (d == DW'(DIMS - 1)) begin
                d <= '0;
                s <= s + AW'(1);
                if (s == AW'(SAMPS - 1)) begin
                  state   <= FULL;
                  start_o <= 1'b1;
                end
              end else begin
                d <= d + DW'(1);
              end
            end
          end
          FULL: begin
            if (label_valid_i) begin
              if (label_bad) label_err_o  <= 1'b1;
              else           lv[addr_i]   <= 1'b1;
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

  // Sample storage: written only on an accepted, non-cleared beat; never reset
  always_ff @(posedge clk_i) begin
    if (accept) mem[s][d] <= in_data_i;
  end

  // Label storage: legal label writes in FULL only; never reset
  always_ff @(posedge clk_i) begin
    if (label_wr && !label_bad) lab[addr_i] <= label_i;
  end

  // Zero-latency read ports for the core and the host
  for (genvar j = 0; j < int'(DIMS); j++) begin : g_rd
    assign membus_o[j] = mem[addr_i][j];
  end

  assign label_o = lab[label_raddr_i];

endmodule

// File: tb/tb_kmeans_sample_store.sv
// Directed bench for kmeans_sample_store: frame loads, reads, labels, clear and reset corners.
module tb_kmeans_sample_store;

  localparam int unsigned W     = 16;
  localparam int unsigned DIMS  = 6;
  localparam int unsigned SAMPS = 128;
  localparam int unsigned K     = 3;
  localparam int unsigned AW    = $clog2(SAMPS);
  localparam int unsigned LW    = $clog2(K);
  localparam int          NBEAT = int'(DIMS * SAMPS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clear;
  logic                   in_valid;
  logic [W-1:0]           in_data;
  logic                   in_ready;
  logic                   start;
  logic                   full;
  logic [AW-1:0]          addr;
  logic [DIMS-1:0][W-1:0] membus;
  logic                   label_valid;
  logic [LW-1:0]          label;
  logic [AW-1:0]          label_raddr;
  logic [LW-1:0]          label_q;
  logic                   labels_done;
  logic                   label_err;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;

  typedef struct {
    logic [AW-1:0]        a;
    logic [DIMS*W-1:0]    exp;
  } rd_vec_t;

  typedef struct {
    logic [AW-1:0]        a;
    logic [LW-1:0]        exp;
  } lab_vec_t;

  rd_vec_t  rv1 [4];
  rd_vec_t  rv2 [2];
  lab_vec_t lvv [5];

  kmeans_sample_store #(.W(W), .DIMS(DIMS), .SAMPS(SAMPS), .K(K)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_ready_o    (in_ready),
    .start_o       (start),
    .full_o        (full),
    .addr_i        (addr),
    .membus_o      (membus),
    .label_valid_i (label_valid),
    .label_i       (label),
    .label_raddr_i (label_raddr),
    .label_o       (label_q),
    .labels_done_o (labels_done),
    .label_err_o   (label_err)
  );

  always #5 clk = ~clk;

  // Count start pulses mid-cycle
  always @(negedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] v, input logic clr);
    in_valid = 1'b0;
    repeat ($urandom_range(0, 1)) tick();
    in_valid = 1'b1;
    in_data  = v;
    clear    = clr;
    #1;
    chk1("beat_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] xr, input int n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] v;
      v = W'(((i / int'(DIMS)) << 8) | (i % int'(DIMS))) ^ xr;
      send_beat(v, 1'b0);
    end
  endtask

  task automatic wr_label(input int a, input int l);
    addr        = AW'(a);
    label       = LW'(l);
    label_valid = 1'b1;
    tick();
    label_valid = 1'b0;
  endtask

  task automatic check_frame_end(input int exp_starts);
    chk1("start_pulse", start, 1'b1);
    chk1("full_at_start", full, 1'b1);
    chk1("ready_in_full", in_ready, 1'b0);
    tick();
    chk1("start_drop", start, 1'b0);
    chk1("full_hold", full, 1'b1);
    chkw("start_count", 128'(start_cnt), 128'(exp_starts));
  endtask

  initial begin
    rv1[0] = '{a: AW'(5),   exp: 96'h0505_0504_0503_0502_0501_0500};
    rv1[1] = '{a: AW'(127), exp: 96'h7F05_7F04_7F03_7F02_7F01_7F00};
    rv1[2] = '{a: AW'(0),   exp: 96'h0005_0004_0003_0002_0001_0000};
    rv1[3] = '{a: AW'(64),  exp: 96'h4005_4004_4003_4002_4001_4000};
    rv2[0] = '{a: AW'(0),   exp: 96'hA005_A004_A003_A002_A001_A000};
    rv2[1] = '{a: AW'(40),  exp: 96'h8805_8804_8803_8802_8801_8800};
    lvv[0] = '{a: AW'(10),  exp: LW'(1)};
    lvv[1] = '{a: AW'(0),   exp: LW'(0)};
    lvv[2] = '{a: AW'(4),   exp: LW'(1)};
    lvv[3] = '{a: AW'(65),  exp: LW'(2)};
    lvv[4] = '{a: AW'(127), exp: LW'(1)};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    addr = '0; label_valid = 1'b0; label = '0; label_raddr = '0;

    // Reset state
    tick();
    chk1("rst_ready", in_ready, 1'b0);
    chk1("rst_start", start, 1'b0);
    chk1("rst_full", full, 1'b0);
    chk1("rst_done", labels_done, 1'b0);
    chk1("rst_err", label_err, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_rst_ready", in_ready, 1'b1);
    tick();

    // Full load and read-back table
    send_frame('0, NBEAT);
    check_frame_end(1);
    for (int i = 0; i < 4; i++) begin
      addr = rv1[i].a;
      #1;
      chkw($sformatf("membus_f1_%0d", i), 128'(membus), 128'(rv1[i].exp));
    end

    // Illegal label at 4, then every other address, then a legal write at 4
    wr_label(4, 3);
    chk1("illegal_err", label_err, 1'b1);
    for (int a = 0; a < int'(SAMPS); a++) if (a != 4) wr_label(a, a % 3);
    chk1("lv4_still_clear", labels_done, 1'b0);
    wr_label(4, 1);
    chk1("lv4_set_done", labels_done, 1'b1);
    chk1("err_sticky", label_err, 1'b1);

    // Clear from FULL, partial frame, then clear together with the beat at s=40 d=2
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk1("clr_full", full, 1'b0);
    chk1("clr_ready", in_ready, 1'b1);
    chk1("clr_err", label_err, 1'b0);
    chk1("clr_done", labels_done, 1'b0);
    send_frame(16'h5000, 242);
    send_beat(16'hDEAD, 1'b1);
    addr = AW'(40);
    #1;
    chkw("dropped_beat", 128'(membus), 128'(96'h2805_2804_2803_2802_7801_7800));
    chk1("clr_beat_full", full, 1'b0);
    send_frame(16'hA000, NBEAT);
    check_frame_end(2);
    for (int i = 0; i < 2; i++) begin
      addr = rv2[i].a;
      #1;
      chkw($sformatf("membus_f2_%0d", i), 128'(membus), 128'(rv2[i].exp));
    end

    // Label sweep 0..127 and label read table
    for (int a = 0; a < int'(SAMPS); a++) begin
      if (a == int'(SAMPS) - 1) chk1("done_before_last", labels_done, 1'b0);
      wr_label(a, a % 3);
    end
    chk1("done_after_last", labels_done, 1'b1);
    chk1("sweep_err", label_err, 1'b0);
    for (int i = 0; i < 5; i++) begin
      label_raddr = lvv[i].a;
      #1;
      chkw($sformatf("label_%0d", i), 128'(label_q), 128'(lvv[i].exp));
    end

    // Clear arriving with the final beat
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send_frame('0, NBEAT - 1);
    send_beat(16'h7F05, 1'b1);
    chk1("clrlast_start", start, 1'b0);
    chk1("clrlast_full", full, 1'b0);
    chk1("clrlast_ready", in_ready, 1'b1);
    tick();
    chk1("clrlast_start2", start, 1'b0);
    chk1("clrlast_full2", full, 1'b0);
    chkw("clrlast_count", 128'(start_cnt), 128'(2));

    // Reset in FULL with labels, then label writes while loading are ignored
    send_frame(16'h3000, NBEAT);
    check_frame_end(3);
    wr_label(4, 3);
    for (int a = 0; a < int'(SAMPS); a++) wr_label(a, a % 3);
    chk1("pre_rst_done", labels_done, 1'b1);
    chk1("pre_rst_err", label_err, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rst_cycle_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk1("rst2_full", full, 1'b0);
    chk1("rst2_done", labels_done, 1'b0);
    chk1("rst2_err", label_err, 1'b0);
    chk1("rst2_ready", in_ready, 1'b1);
    wr_label(10, 2);
    wr_label(4, 3);
    label_raddr = AW'(10);
    #1;
    chkw("load_label_ignored", 128'(label_q), 128'(1));
    chk1("load_done_ignored", labels_done, 1'b0);
    chk1("load_err_ignored", label_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
